// File: rtl/sseg_scan_decoder.sv
// Recovers HH:MM:SS from a multiplexed, active-low 6-digit seven-segment scan.
// Digits are debounced by dwell time, collected into a shadow frame and published atomically.
module sseg_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 2_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] an,
    input  logic [7:0] sseg,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [5:0] dp,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       stale
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    logic [5:0]       an_q, an_p_q;
    logic [7:0]       sseg_q, sseg_p_q;
    logic [7:0]       cnt_q, cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [5:0]       mask_q, mask_d;
    logic [5:0]       dp_sh_q, dp_sh_d;
    logic [23:0]      shadow_q, shadow_d;
    logic [23:0]      pub_q;
    logic [5:0]       dp_q;
    logic             frame_valid_q;
    logic             seg_err_q, seg_err_d;
    logic             stale_q, stale_d;

    logic       changed, accept, capture, one_hot, full, timeout;
    logic [5:0] sel;
    logic       dec_ok;
    logic [3:0] dec_val;

    // Returns {valid, hex value} for an active-low 7-segment pattern {g..a}.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h0F;
        unique case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h0F;
        endcase
        return r;
    endfunction

    always_comb begin
        changed = {an_q, sseg_q} != {an_p_q, sseg_p_q};
        if (changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q == 8'(SETTLE)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        // Fires only on the transition into SETTLE, so a long dwell is accepted once.
        accept  = !changed && (cnt_q == 8'(SETTLE - 1)) && (an_q != 6'h3F);
        sel     = ~an_q;
        one_hot = $onehot(sel);
        capture = accept && one_hot;
        {dec_ok, dec_val} = decode(sseg_q[6:0]);

        full    = mask_q == 6'h3F;
        timeout = (idle_q == IdleW'(TIMEOUT)) && (mask_q != 6'h00) && !full;

        mask_d   = (full || timeout) ? 6'h00 : mask_q;
        shadow_d = shadow_q;
        dp_sh_d  = dp_sh_q;
        if (capture) begin
            mask_d = mask_d | sel;
            for (int k = 0; k < 6; k++) begin
                if (sel[k]) begin
                    shadow_d[4*k +: 4] = dec_ok ? dec_val : 4'hF;
                    dp_sh_d[k]         = ~sseg_q[7];
                end
            end
        end

        seg_err_d = seg_err_q | (accept && (!one_hot || !dec_ok));

        if (capture) begin
            idle_d = '0;
        end else if (idle_q == IdleW'(TIMEOUT)) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IdleW'(1);
        end

        if (full) begin
            stale_d = 1'b0;
        end else if (timeout) begin
            stale_d = 1'b1;
        end else begin
            stale_d = stale_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q          <= 6'h3F;
            an_p_q        <= 6'h3F;
            sseg_q        <= 8'hFF;
            sseg_p_q      <= 8'hFF;
            cnt_q         <= '0;
            idle_q        <= '0;
            mask_q        <= '0;
            dp_sh_q       <= '0;
            shadow_q      <= '0;
            pub_q         <= '0;
            dp_q          <= '0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            an_q          <= an;
            an_p_q        <= an_q;
            sseg_q        <= sseg;
            sseg_p_q      <= sseg_q;
            cnt_q         <= cnt_d;
            idle_q        <= idle_d;
            mask_q        <= mask_d;
            dp_sh_q       <= dp_sh_d;
            shadow_q      <= shadow_d;
            frame_valid_q <= full;
            seg_err_q     <= seg_err_d;
            stale_q       <= stale_d;
            if (full) begin
                pub_q <= shadow_q;
                dp_q  <= dp_sh_q;
            end
        end
    end

    assign hour        = pub_q[23:16];
    assign min         = pub_q[15:8];
    assign sec         = pub_q[7:0];
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign stale       = stale_q;

endmodule
